// File: rtl/wb_spi_master_ctrl.sv
// Wishbone B4 classic slave driving a single-chip-select, mode-0, MSB-first SPI master.
// Registers: 0 DATA, 1 STATUS, 2 DIV, 3 CS (word addressed through adr[3:2]).
module wb_spi_master_ctrl #(
    parameter logic [7:0] DEFAULT_DIV = 8'd11
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic        spi_cs0_o
);
    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

    state_t     r_state;
    logic       r_ack;
    logic [7:0] r_tx;
    logic [7:0] r_shift;
    logic [7:0] r_rx;
    logic [7:0] r_div;
    logic [7:0] r_div_l;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic       r_busy;
    logic       r_done;
    logic       r_cs;
    logic       r_sck;
    logic       r_mosi;

    logic       w_req;
    logic       w_wr;
    logic       w_rd;
    logic [1:0] w_reg;
    logic       w_start;
    logic       w_half_end;
    logic       w_unused;

    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_reg      = wb_adr_i[3:2];
    assign w_wr       = r_ack & w_req & wb_we_i & wb_sel_i[0];
    assign w_rd       = r_ack & w_req & ~wb_we_i;
    assign w_start    = w_wr && (w_reg == 2'd0) && (r_state == S_IDLE);
    assign w_half_end = (r_cnt == r_div_l);
    assign w_unused   = &{1'b0, wb_dat_i[31:8], wb_sel_i[3:1], wb_adr_i[1:0]};

    assign wb_ack_o   = r_ack;
    assign spi_sck_o  = r_sck;
    assign spi_mosi_o = r_mosi;
    assign spi_cs0_o  = r_cs;

    // Read data is only presented during the ack cycle; zero otherwise.
    always_comb begin
        wb_dat_o = 32'd0;
        if (r_ack) begin
            case (w_reg)
                2'd0:    wb_dat_o = {24'd0, r_rx};
                2'd1:    wb_dat_o = {30'd0, r_done, r_busy};
                2'd2:    wb_dat_o = {24'd0, r_div};
                default: wb_dat_o = {31'd0, r_cs};
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs    <= 1'b1;
            r_div   <= DEFAULT_DIV;
            r_div_l <= DEFAULT_DIV;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rx    <= 8'd0;
            r_tx    <= 8'd0;
            r_shift <= 8'd0;
            r_cnt   <= 8'd0;
            r_bit   <= 3'd0;
        end else begin
            r_ack <= w_req & ~r_ack;
            if (w_wr && w_reg == 2'd2) r_div <= wb_dat_i[7:0];
            if (w_wr && w_reg == 2'd3) r_cs  <= wb_dat_i[0];
            // Clear first so that a DONE set later in this block wins.
            if (w_rd && w_reg == 2'd0) r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_sck <= 1'b0;
                    if (w_start) begin
                        r_tx    <= wb_dat_i[7:0];
                        r_mosi  <= wb_dat_i[7];
                        r_div_l <= r_div;
                        r_cnt   <= 8'd0;
                        r_bit   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_half_end) begin
                        r_cnt   <= 8'd0;
                        r_sck   <= 1'b1;
                        r_shift <= {r_shift[6:0], spi_miso_i};
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (w_half_end) begin
                        r_cnt <= 8'd0;
                        r_sck <= 1'b0;
                        if (r_bit == 3'd7) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_rx    <= r_shift;
                            r_state <= S_IDLE;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= {r_tx[6:0], 1'b0};
                            r_mosi  <= r_tx[6];
                            r_state <= S_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_spi_master_ctrl.sv
// Scoreboard bench for wb_spi_master_ctrl: expected MOSI bits are queued per transfer
// and popped on every SCK rising edge; register reads are compared against constants.
module tb_wb_spi_master_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [31:0] dat_o;
    logic        ack, sck, mosi, miso, cs0;
    logic        loop_en, miso_val;

    assign miso = loop_en ? mosi : miso_val;

    wb_spi_master_ctrl #(.DEFAULT_DIV(8'd11)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .spi_sck_o(sck), .spi_mosi_o(mosi),
        .spi_miso_i(miso), .spi_cs0_o(cs0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];
    int cyc_n = 0, n_fall = 0, last_rise = 0, last_fall = 0, first_rise = 0;
    int exp_half = 12;
    bit sck_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // SCK monitor: pops the scoreboard on each rise and checks half-period widths.
    always @(posedge clk) begin
        #1;
        cyc_n++;
        if (sck && !sck_prev) begin
            if (exp_q.size() == 0) check("extra_sck", 1, 0);
            else check("mosi_bit", mosi, exp_q.pop_front());
            if (n_fall > 0) check("sck_low_w", cyc_n - last_fall, exp_half);
            else first_rise = cyc_n;
            last_rise = cyc_n;
        end
        if (!sck && sck_prev) begin
            n_fall++;
            check("sck_high_w", cyc_n - last_rise, exp_half);
            last_fall = cyc_n;
        end
        sck_prev = sck;
    end

    task automatic wb_access(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic w, output logic [31:0] rd);
        bit got = 0;
        @(negedge clk);
        adr = a; dat_i = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1;
        end
        if (!got) check("ack_timeout", 0, 1);
        rd = dat_o;
        @(posedge clk); #1;
        check("ack_single", ack, 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_access(a, d, s, 1'b1, dummy);
    endtask

    task automatic wb_read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        wb_access(a, 32'd0, 4'hF, 1'b0, rd);
        check(tag, rd, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    endtask

    task automatic wait_falls(input int n, input int budget);
        int k = 0;
        while (n_fall < n && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        if (n_fall < n) check("sck_timeout", n_fall, n);
    endtask

    task automatic run_xfer(input logic [7:0] tx, input int div, input logic [7:0] rx_exp,
                            input bit busy_write);
        wb_write(4'h8, div, 4'h1);
        wb_read_chk("div_rb", 4'h8, div);
        n_fall = 0;
        exp_half = div + 1;
        push_byte(tx);
        wb_write(4'h0, {24'd0, tx}, 4'h1);
        wb_read_chk("status_busy", 4'h4, 32'h1);
        if (busy_write) wb_write(4'h0, 32'h12, 4'h1);
        wait_falls(8, 40 * (div + 1));
        check("busy_span", last_fall - first_rise, 15 * (div + 1));
        check("q_empty", exp_q.size(), 0);
        wb_read_chk("status_done", 4'h4, 32'h2);
        wb_read_chk("data_rx", 4'h0, {24'd0, rx_exp});
        wb_read_chk("status_clr", 4'h4, 32'h0);
        repeat (40) @(posedge clk);
        check("no_extra_xfer", n_fall, 8);
    endtask

    initial begin
        rst = 1'b1; adr = 0; dat_i = 0; sel = 0; we = 0; cyc = 0; stb = 0;
        loop_en = 1'b1; miso_val = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        check("rst_sck", sck, 0);
        check("rst_cs0", cs0, 1);
        wb_read_chk("rst_div", 4'h8, 32'd11);
        wb_read_chk("rst_cs", 4'hC, 32'd1);
        wb_read_chk("rst_status", 4'h4, 32'd0);

        // Loopback 0xA5 at full speed.
        run_xfer(8'hA5, 0, 8'hA5, 1'b0);

        // MISO tied high, slower clock.
        loop_en = 1'b0; miso_val = 1'b1;
        run_xfer(8'h00, 3, 8'hFF, 1'b0);
        loop_en = 1'b1;

        // A DATA write while busy must be acked and dropped.
        run_xfer(8'h34, 1, 8'h34, 1'b1);

        // Reset in the middle of a transfer after bit 3.
        wb_write(4'h8, 32'd1, 4'h1);
        wb_write(4'hC, 32'd0, 4'h1);
        check("cs0_low_pre", cs0, 0);
        n_fall = 0; exp_half = 2;
        push_byte(8'hC3);
        wb_write(4'h0, 32'hC3, 4'h1);
        wait_falls(4, 40);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_sck", sck, 0);
        check("abort_cs0", cs0, 1);
        @(negedge clk); rst = 1'b0;
        exp_q.delete();
        wb_read_chk("abort_status", 4'h4, 32'h0);
        wb_read_chk("abort_div", 4'h8, 32'd11);
        run_xfer(8'h5A, 11, 8'h5A, 1'b0);

        // Chip select byte-lane gating.
        wb_write(4'hC, 32'd0, 4'b0010);
        check("cs_sel_gate", cs0, 1);
        wb_read_chk("cs_rb_gate", 4'hC, 32'd1);
        wb_write(4'hC, 32'd0, 4'b0001);
        check("cs_write", cs0, 0);
        wb_read_chk("cs_rb", 4'hC, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_spi_master_ctrl.md
WB_SPI_MASTER_CTRL -- requirements
Module: wb_spi_master_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 11, meaning the reset value of the DIV register (1 MHz SCK from 24 MHz).
REQ-002 SHALL have port wb_clk_i, input, 1 bit: sole clock; all logic rises on it.
REQ-003 SHALL have port wb_rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port wb_adr_i, input, 4 bits: byte address; bits [3:2] select the register, bits [1:0] are ignored.
REQ-005 SHALL have port wb_dat_i, input, 32 bits: write data.
REQ-006 SHALL have port wb_sel_i, input, 4 bits: byte lanes; only sel[0] gates writes.
REQ-007 SHALL have ports wb_we_i, wb_cyc_i and wb_stb_i, each input, 1 bit: Wishbone B4 classic controls.
REQ-008 SHALL have port wb_dat_o, output, 32 bits: read data.
REQ-009 SHALL have port wb_ack_o, output, 1 bit: transfer acknowledge.
REQ-010 SHALL have port spi_sck_o, output, 1 bit: SPI clock, mode 0.
REQ-011 SHALL have port spi_mosi_o, output, 1 bit: serial data out, MSB first.
REQ-012 SHALL have port spi_miso_i, input, 1 bit: serial data in.
REQ-013 SHALL have port spi_cs0_o, output, 1 bit: chip select, active low, software controlled.

Function
REQ-014 SHALL pulse wb_ack_o for exactly one cycle, in the cycle after cyc&stb is seen with ack low; back-to-back accesses are therefore acked every second cycle.
REQ-015 SHALL apply a register write, gated by we&sel[0], in the ack cycle.
REQ-016 SHALL drive read data on wb_dat_o in the ack cycle, with unused bits 0.
REQ-017 SHALL implement register 0 DATA: a write loads tx[7:0] and starts a transfer only if the block is idle, and is acked but ignored if busy; a read returns rx[7:0] and clears DONE.
REQ-018 SHALL implement register 1 STATUS (read-only): bit0 BUSY, bit1 DONE; DONE is sticky, set at transfer end and cleared by a DATA read or a DATA write that starts a transfer.
REQ-019 SHALL implement register 2 DIV[7:0] (read/write): SCK half-period = DIV+1 wb_clk_i cycles.
REQ-020 SHALL implement register 3 CS: bit0 drives spi_cs0_o directly; it is read/write and writable while busy.
REQ-021 SHALL implement FSM states IDLE, LOW and HIGH.
REQ-022 In IDLE, SHALL hold SCK=0, with MOSI keeping its last value.
REQ-023 On a start, SHALL in the next cycle enter LOW, set BUSY=1, set MOSI=tx[7], clear the divider counter and set bit_cnt=0.
REQ-024 SHALL increment the divider counter every cycle in LOW/HIGH; a half-period ends when counter==DIV, and the counter then resets to 0.
REQ-025 At the end of LOW, SHALL set SCK=1, sample MISO into the shift register LSB (shift left), and enter HIGH.
REQ-026 At the end of HIGH, SHALL set SCK=0; if bit_cnt==7 it SHALL enter IDLE, set BUSY=0 and DONE=1, and latch rx; otherwise it SHALL increment bit_cnt, drive the next tx bit on MOSI and enter LOW.
REQ-027 SHALL take 16*(DIV+1) cycles from entering LOW to BUSY falling, giving 8 SCK pulses.
REQ-028 SHALL latch DIV at transfer start; DIV writes during a transfer take effect at the next transfer.
REQ-029 If DONE set and a DATA read occur in the same cycle, the set SHALL win.

Reset
REQ-030 On wb_rst_i high at a clock edge, SHALL force FSM=IDLE, SCK=0, MOSI=0, CS=1, DIV=DEFAULT_DIV, BUSY=0, DONE=0, rx=0, wb_ack_o=0; this applies mid-transfer or mid-bus-cycle, with the transfer aborted and no ack issued.

Verification
REQ-031 SHALL pass: reset -> read DIV=11, CS=1, STATUS=0, SCK=0, cs0=1.
REQ-032 SHALL pass: DIV=0, write DATA=0xA5 with MISO looped to MOSI -> 8 SCK pulses 1 cycle high/low each, MOSI sequence 1,0,1,0,0,1,0,1, BUSY high 16 cycles, then STATUS=0x2 and DATA read=0xA5, then STATUS=0x0.
REQ-033 SHALL pass: DIV=3, MISO tied 1, DATA=0x00 -> SCK half-period 4 cycles, 64 busy cycles, rx=0xFF.
REQ-034 SHALL pass: write DATA=0x12 while busy with 0x34 -> ack given, MOSI carries 0x34 only, no second transfer.
REQ-035 SHALL pass: assert wb_rst_i after bit 3 of a transfer -> next cycle SCK=0, BUSY=0, CS=1; a subsequent transfer of 0x5A completes normally.
REQ-036 SHALL pass: write CS=0 with sel=4'b0010 -> no effect, cs0 stays 1; write CS=0 with sel=4'b0001 -> cs0=0 in the ack cycle+1.
